// File: rtl/ram_stream_reader.sv
// Read-side controller for a small dual-port RAM: walks base..base+len-1
// (wrapping), absorbs the 1-cycle read latency and emits a valid/ready stream.
//
// Ports:
//   clock, rst_n          clock / async active-low reset
//   start, base_addr, len command (sampled in IDLE only)
//   rd_addr -> RAM        registered read address
//   ram_q   <- RAM        read data, valid the cycle after rd_addr
//   out_data/out_valid    stream output, out_ready from the consumer
//   busy, done            command status; done is a one-cycle pulse
module ram_stream_reader #(
  parameter int AW = 3,
  parameter int DW = 4
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   len,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] ram_q,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW:0]   r_rem;
  logic [AW-1:0] r_rd_addr;
  logic          r_infl;
  logic [1:0]    r_cnt;
  logic [DW-1:0] r_buf0;
  logic [DW-1:0] r_buf1;
  logic          r_valid;

  logic          w_pop;
  logic          w_issue;
  logic          w_accept;
  logic          w_last;
  logic [2:0]    w_occ;
  logic [1:0]    w_cnt_nxt;

  assign w_pop = r_valid & out_ready;

  // Words held or in flight. A beat leaving this cycle frees its slot
  // early, so a read can issue every cycle while the consumer keeps up.
  assign w_occ = {1'b0, r_cnt} + {2'b00, r_infl}
               - {2'b00, w_pop};

  assign w_issue = (r_state == S_RUN)
                && (r_rem != '0)
                && (w_occ < 3'd2);

  assign w_last = w_issue
               && (r_rem == (AW+1)'(1));

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            w_accept    = 1'b1;
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (r_rem == '0 || w_last)
          w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // Leave as the final beat departs so
        // done lands on the following cycle.
        if (!r_infl &&
            (r_cnt == 2'd0 ||
             (r_cnt == 2'd1 && w_pop)))
          w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (r_infl && !w_pop)
      w_cnt_nxt = r_cnt + 2'd1;
    else if (!r_infl && w_pop)
      w_cnt_nxt = r_cnt - 2'd1;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_rem     <= '0;
      r_rd_addr <= '0;
      r_infl    <= 1'b0;
      r_cnt     <= 2'd0;
      r_buf0    <= '0;
      r_buf1    <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_rem     <= len;
        r_rd_addr <= base_addr;
      end else if (w_issue) begin
        r_rem     <= r_rem - (AW+1)'(1);
        r_rd_addr <= r_rd_addr + AW'(1);
      end
      r_infl  <= w_issue;
      r_cnt   <= w_cnt_nxt;
      r_valid <= (w_cnt_nxt != 2'd0);
      // Head is r_buf0. A pop shifts; a capture
      // lands in the first free slot after it.
      if (w_pop) begin
        r_buf0 <= (r_cnt == 2'd1) ? ram_q : r_buf1;
        r_buf1 <= ram_q;
      end else if (r_infl) begin
        if (r_cnt == 2'd0)
          r_buf0 <= ram_q;
        else
          r_buf1 <= ram_q;
      end
    end
  end

  assign rd_addr   = r_rd_addr;
  assign out_data  = r_buf0;
  assign out_valid = r_valid;
  assign busy      = (r_state == S_RUN)
                  || (r_state == S_DRAIN);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: behavioural RAM with mem[i]=i+5,
// scoreboard of expected beats, one task per scenario.
module tb_ram_stream_reader;
  localparam int AW = 3;
  localparam int DW = 4;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len = '0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] ram_q;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [8];
  logic [DW-1:0] exp_q [$];
  logic [AW-1:0] exp_rd;
  int            n_cmp = 0;
  int            n_err = 0;

  always #5 clock = ~clock;

  always @(posedge clock) ram_q <= mem[rd_addr];

  ram_stream_reader #(.AW(AW), .DW(DW)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .rd_addr   (rd_addr),
    .ram_q     (ram_q),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  // Drives a start (caller is at a negedge) and queues expected beats.
  task automatic launch(input logic [AW-1:0] b, input logic [AW:0] l);
    for (int i = 0; i < int'(l); i++)
      exp_q.push_back(mem[(int'(b) + i) % 8]);
    if (l != '0) exp_rd = 3'((int'(b) + int'(l)) % 8);
    base_addr = b;
    len       = l;
    start     = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++;
    if ({rd_addr, out_data, out_valid, busy, done} !== 10'd0) begin
      n_err++;
      $display("FAIL reset_hold got rd=%0d data=%h v=%b busy=%b done=%b required all 0", rd_addr, out_data, out_valid, busy, done);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clock);
    n_cmp++;
    if ({rd_addr, out_valid, busy, done} !== 6'd0) begin
      n_err++;
      $display("FAIL reset_release got rd=%0d v=%b busy=%b done=%b required 0", rd_addr, out_valid, busy, done);
    end
    exp_rd = '0;
  endtask

  task automatic test_basic;
    int first_v, last_b, done_c;
    logic [DW-1:0] e;
    first_v = -1; last_b = -1; done_c = -1;
    out_ready = 1'b1;
    launch(3'd2, 4'd3);
    for (int c = 1; c <= 30 && done_c < 0; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (c == 1) begin
        n_cmp++;
        if (rd_addr !== 3'd2 || busy !== 1'b1) begin
          n_err++;
          $display("FAIL basic_issue rd=%0d busy=%b required rd=2 busy=1", rd_addr, busy);
        end
      end
      if (out_valid && first_v < 0) first_v = c;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL basic_extra beat %h required none", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            n_err++;
            $display("FAIL basic_beat got %h required %h", out_data, e);
          end
        end
        if (last_b >= 0) begin
          n_cmp++;
          if (c != last_b + 1) begin
            n_err++;
            $display("FAIL basic_gap beat cycle %0d required %0d", c, last_b + 1);
          end
        end
        last_b = c;
      end
      if (done) begin
        done_c = c;
        n_cmp++;
        if (busy !== 1'b0) begin
          n_err++;
          $display("FAIL basic_busy_at_done got %b required 0", busy);
        end
      end
    end
    n_cmp++;
    if (first_v != 3) begin
      n_err++;
      $display("FAIL basic_latency first valid cycle %0d required 3", first_v);
    end
    n_cmp++;
    if (done_c < 0 || done_c != last_b + 1 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL basic_done done cycle %0d last beat %0d left %0d required done=last+1 left 0", done_c, last_b, exp_q.size());
    end
    @(negedge clock);
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL basic_pulse done=%b required 0", done);
    end
  endtask

  task automatic test_wrap;
    logic [DW-1:0] e;
    logic [AW-1:0] a;
    bit fin;
    fin = 1'b0;
    out_ready = 1'b1;
    launch(3'd6, 4'd4);
    for (int c = 1; c <= 30 && !fin; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (c <= 4) begin
        a = 3'((6 + c - 1) % 8);
        n_cmp++;
        if (rd_addr !== a) begin
          n_err++;
          $display("FAIL wrap_addr c=%0d got %0d required %0d", c, rd_addr, a);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
        if (out_data !== e) begin
          n_err++;
          $display("FAIL wrap_beat got %h required %h", out_data, e);
        end
      end
      if (done) fin = 1'b1;
    end
    n_cmp++;
    if (!fin || exp_q.size() != 0 || rd_addr !== exp_rd) begin
      n_err++;
      $display("FAIL wrap_end done=%b left=%0d rd=%0d required done left 0 rd %0d", fin, exp_q.size(), rd_addr, exp_rd);
    end
    @(negedge clock);
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] e;
    int nb, stall;
    bit fin;
    nb = 0; stall = 0; fin = 1'b0;
    out_ready = 1'b1;
    launch(3'd0, 4'd8);
    for (int c = 1; c <= 60 && !fin; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (nb == 2 && stall < 5) begin
        out_ready = 1'b0;
        stall++;
      end else begin
        out_ready = 1'b1;
      end
      if (!out_ready) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== exp_q[0] || int'(rd_addr) > nb + 2) begin
          n_err++;
          $display("FAIL bp_stall c=%0d v=%b data=%h rd=%0d required v=1 data=%h rd<=%0d", c, out_valid, out_data, rd_addr, exp_q[0], nb + 2);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
        if (out_data !== e) begin
          n_err++;
          $display("FAIL bp_beat %0d got %h required %h", nb, out_data, e);
        end
        nb++;
      end
      if (done) fin = 1'b1;
    end
    out_ready = 1'b1;
    n_cmp++;
    if (!fin || nb != 8 || exp_q.size() != 0 || stall != 5) begin
      n_err++;
      $display("FAIL bp_end done=%b beats=%0d stalls=%0d required done beats=8 stalls=5", fin, nb, stall);
    end
    @(negedge clock);
  endtask

  task automatic test_len0;
    launch(3'd5, 4'd0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      start = 1'b0;
      n_cmp++;
      if (done !== (c == 1) || out_valid !== 1'b0 || busy !== 1'b0 || rd_addr !== exp_rd) begin
        n_err++;
        $display("FAIL len0 c=%0d done=%b v=%b busy=%b rd=%0d required done=%b v=0 busy=0 rd=%0d", c, done, out_valid, busy, rd_addr, c == 1, exp_rd);
      end
    end
  endtask

  task automatic test_ignore_start;
    logic [DW-1:0] e;
    int nb;
    bit fin;
    for (int k = 0; k < 2; k++) begin
      nb = 0; fin = 1'b0;
      out_ready = 1'b1;
      if (k == 0) launch(3'd1, 4'd3);
      else        launch(3'd5, 4'd2);
      for (int c = 1; c <= 30 && !fin; c++) begin
        @(negedge clock);
        start = 1'b0;
        if (k == 0 && (c == 2 || c == 4)) begin
          base_addr = 3'd5;
          len       = 4'd6;
          start     = 1'b1;
        end
        if (out_valid && out_ready) begin
          n_cmp++;
          e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
          if (out_data !== e) begin
            n_err++;
            $display("FAIL ign_beat cmd %0d got %h required %h", k, out_data, e);
          end
          nb++;
        end
        if (done) fin = 1'b1;
      end
      start = 1'b0;
      n_cmp++;
      if (!fin || nb != 3 - k || rd_addr !== exp_rd) begin
        n_err++;
        $display("FAIL ign_end cmd %0d done=%b beats=%0d rd=%0d required beats=%0d rd=%0d", k, fin, nb, rd_addr, 3 - k, exp_rd);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset_mid;
    logic [DW-1:0] e;
    int nb;
    bit fin;
    nb = 0;
    out_ready = 1'b1;
    launch(3'd0, 4'd8);
    for (int c = 1; c <= 30 && nb < 3; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (out_data !== e) begin
          n_err++;
          $display("FAIL rmid_beat got %h required %h", out_data, e);
        end
        nb++;
      end
    end
    @(negedge clock);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_async v=%b busy=%b done=%b required 0", out_valid, busy, done);
    end
    exp_q.delete();
    exp_rd = '0;
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      n_cmp++;
      if (out_valid !== 1'b0 || done !== 1'b0 || rd_addr !== 3'd0) begin
        n_err++;
        $display("FAIL rmid_quiet v=%b done=%b rd=%0d required 0", out_valid, done, rd_addr);
      end
    end
    nb = 0; fin = 1'b0;
    launch(3'd4, 4'd2);
    for (int c = 1; c <= 30 && !fin; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (out_valid && out_ready) begin
        n_cmp++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
        if (out_data !== e) begin
          n_err++;
          $display("FAIL rmid_new got %h required %h", out_data, e);
        end
        nb++;
      end
      if (done) fin = 1'b1;
    end
    n_cmp++;
    if (!fin || nb != 2) begin
      n_err++;
      $display("FAIL rmid_end done=%b beats=%0d required done beats=2", fin, nb);
    end
    @(negedge clock);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 4'(i + 5);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len0();
    test_ignore_start();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
